// File: rtl/point_plotter_if.sv
// point_plotter_if: groups the projected-point input stream, the frame
// control/status lines and the frame buffer write bus of point_plotter.
interface point_plotter_if #(
  parameter int COLOR_W = 8
);
  logic [8:0]         x_in;
  logic [7:0]         y_in;
  logic               valid_in;
  logic               frame_start_in;
  logic               ready_out;
  logic               wr_en_out;
  logic [16:0]        wr_addr_out;
  logic [COLOR_W-1:0] wr_data_out;
  logic               busy_out;
  logic [16:0]        plotted_cnt_out;
  logic [16:0]        dropped_cnt_out;

  // Upstream side: the projection stage feeding points and frame pulses.
  modport master (
    output x_in, y_in, valid_in, frame_start_in,
    input  ready_out, wr_en_out, wr_addr_out, wr_data_out, busy_out,
           plotted_cnt_out, dropped_cnt_out
  );

  // Plotter side.
  modport slave (
    input  x_in, y_in, valid_in, frame_start_in,
    output ready_out, wr_en_out, wr_addr_out, wr_data_out, busy_out,
           plotted_cnt_out, dropped_cnt_out
  );
endinterface

// File: rtl/point_plotter.sv
// point_plotter: clears a frame buffer to the background colour on every
// frame start, then turns each projected screen point into a single pixel
// write. Off-screen points and points arriving outside DRAW are counted.
module point_plotter #(
  parameter int                 H_RES       = 320,
  parameter int                 V_RES       = 240,
  parameter int                 COLOR_W     = 8,
  parameter logic [COLOR_W-1:0] POINT_COLOR = 8'hFF,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 8'h00
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  point_plotter_if.slave   plot_if
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW} state_t;

  localparam int          PIXELS    = H_RES * V_RES;
  localparam logic [16:0] LAST_ADDR = 17'(PIXELS - 1);
  localparam logic [16:0] CNT_MAX   = '1;
  localparam logic [9:0]  X_LIMIT   = 10'(H_RES);
  localparam logic [8:0]  Y_LIMIT   = 9'(V_RES);

  state_t             r_state;
  logic [16:0]        r_clearCnt;
  logic               r_s1Valid;
  logic               r_s1InRange;
  logic [8:0]         r_s1X;
  logic [7:0]         r_s1Y;
  logic               r_wrEn;
  logic [16:0]        r_wrAddr;
  logic [COLOR_W-1:0] r_wrData;
  logic [16:0]        r_plotted;
  logic [16:0]        r_dropped;

  logic        w_inRange;
  logic        w_stateDrop;
  logic        w_rangeDrop;
  logic        w_plotWrite;
  logic [16:0] w_pointAddr;
  logic [1:0]  w_dropInc;
  logic [17:0] w_dropSum;
  logic [17:0] w_plotSum;
  logic [16:0] w_droppedNext;
  logic [16:0] w_plottedNext;

  // Range test on the incoming point; negative upstream values arrive as
  // large unsigned numbers and so fall out of range naturally.
  assign w_inRange = ({1'b0, plot_if.x_in} < X_LIMIT) && ({1'b0, plot_if.y_in} < Y_LIMIT);

  // A point is rejected by state when it arrives outside DRAW; a point on a
  // frame_start cycle is simply ignored, not counted.
  assign w_stateDrop = plot_if.valid_in && !plot_if.frame_start_in && (r_state != DRAW);
  assign w_rangeDrop = r_s1Valid && !r_s1InRange;
  assign w_plotWrite = r_s1Valid && r_s1InRange;

  // y*H_RES + x; for H_RES=320 this is (y<<8)+(y<<6)+x and cannot
  // overflow 17 bits for in-range points.
  assign w_pointAddr = 17'(r_s1Y) * 17'(H_RES) + 17'(r_s1X);

  // Saturating counter updates; a state drop and a range drop can in
  // principle land on the same edge, so the drop increment is two bits.
  assign w_dropInc     = {1'b0, w_stateDrop} + {1'b0, w_rangeDrop};
  assign w_dropSum     = {1'b0, r_dropped} + 18'(w_dropInc);
  assign w_plotSum     = {1'b0, r_plotted} + 18'(w_plotWrite);
  assign w_droppedNext = w_dropSum[17] ? CNT_MAX : w_dropSum[16:0];
  assign w_plottedNext = w_plotSum[17] ? CNT_MAX : w_plotSum[16:0];

  // Status lines decode straight from the state register.
  assign plot_if.ready_out = (r_state == DRAW);
  assign plot_if.busy_out  = (r_state == CLEAR);

  assign plot_if.wr_en_out       = r_wrEn;
  assign plot_if.wr_addr_out     = r_wrAddr;
  assign plot_if.wr_data_out     = r_wrData;
  assign plot_if.plotted_cnt_out = r_plotted;
  assign plot_if.dropped_cnt_out = r_dropped;

  // Frame FSM, clear sequencer, two-stage plot pipeline and counters.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= IDLE;
      r_clearCnt  <= '0;
      r_s1Valid   <= 1'b0;
      r_s1InRange <= 1'b0;
      r_s1X       <= '0;
      r_s1Y       <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_plotted   <= '0;
      r_dropped   <= '0;
    end else if (plot_if.frame_start_in) begin
      r_state    <= CLEAR;
      r_clearCnt <= '0;
      r_s1Valid  <= 1'b0;
      r_wrEn     <= 1'b1;
      r_wrAddr   <= '0;
      r_wrData   <= BG_COLOR;
      r_plotted  <= '0;
      r_dropped  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_s1Valid <= 1'b0;
          r_wrEn    <= 1'b0;
          r_dropped <= w_droppedNext;
        end
        CLEAR: begin
          r_s1Valid <= 1'b0;
          r_dropped <= w_droppedNext;
          if (r_clearCnt == LAST_ADDR) begin
            r_state <= DRAW;
            r_wrEn  <= 1'b0;
          end else begin
            r_clearCnt <= r_clearCnt + 17'd1;
            r_wrEn     <= 1'b1;
            r_wrAddr   <= r_clearCnt + 17'd1;
            r_wrData   <= BG_COLOR;
          end
        end
        DRAW: begin
          r_s1Valid <= plot_if.valid_in;
          if (plot_if.valid_in) begin
            r_s1X       <= plot_if.x_in;
            r_s1Y       <= plot_if.y_in;
            r_s1InRange <= w_inRange;
          end
          r_wrEn <= w_plotWrite;
          if (w_plotWrite) begin
            r_wrAddr <= w_pointAddr;
            r_wrData <= POINT_COLOR;
          end
          r_plotted <= w_plottedNext;
          r_dropped <= w_droppedNext;
        end
        default: begin
          r_state <= IDLE;
          r_wrEn  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_point_plotter.sv
// tb_point_plotter: drives point_plotter with directed and random point
// streams and compares every output on every cycle against a frame-level
// reference model, plus hand-computed literal checkpoints.
module tb_point_plotter;

  localparam int H = 320;
  localparam int V = 12;
  localparam int PIX = H * V;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  point_plotter_if #(.COLOR_W(8)) bus ();

  point_plotter #(
    .H_RES(H), .V_RES(V), .COLOR_W(8), .POINT_COLOR(8'hFF), .BG_COLOR(8'h00)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .plot_if(bus)
  );

  int compared = 0;
  int failed   = 0;
  bit checkEn  = 1'b0;

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic v, input logic [8:0] x, input logic [7:0] y);
    @(posedge clk);
    #1;
    bus.frame_start_in = fs;
    bus.valid_in       = v;
    bus.x_in           = x;
    bus.y_in           = y;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
  endtask

  task automatic waitReady(input int limit);
    int k;
    k = 0;
    while (k < limit) begin
      applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
      @(negedge clk);
      if (bus.ready_out === 1'b1) break;
      k++;
    end
    checkOutput("readyWithinBound", 32'(bus.ready_out), 32'd1);
  endtask

  task automatic randomCycles(input int n);
    logic       v;
    logic [8:0] x;
    logic [7:0] y;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(0, 3) != 0);
      x = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(H, 511)) : 9'($urandom_range(0, H - 1));
      y = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(V, 255)) : 8'($urandom_range(0, V - 1));
      applyStimulus(1'b0, v, x, y);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [8:0] x;
    logic [7:0] y;
  } pt_t;

  pt_t  pending[$];
  int   cyc = 0;
  bit   everFs;
  int   lastFs;
  int   expPlot, expDrop;
  bit   expWr;
  int   expAddr, expData;
  bit   expReady, expBusy;

  function automatic bit inDraw(input int n);
    return everFs && ((n - lastFs) > PIX);
  endfunction

  function automatic bit inClear(input int n);
    return everFs && ((n - lastFs) >= 1) && ((n - lastFs) <= PIX);
  endfunction

  // Model: from the inputs of cycle cyc, work out what the outputs must
  // show during cycle cyc+1.
  always @(posedge clk or negedge rst_n) begin
    pt_t p;
    if (!rst_n) begin
      pending.delete();
      everFs = 1'b0; lastFs = 0; expPlot = 0; expDrop = 0;
      expWr = 1'b0; expAddr = 0; expData = 0; expReady = 1'b0; expBusy = 1'b0;
    end else begin
      if (bus.frame_start_in) begin
        everFs = 1'b1; lastFs = cyc;
        pending.delete();
        expPlot = 0; expDrop = 0;
      end else if (bus.valid_in) begin
        if (inDraw(cyc)) pending.push_back('{cyc + 2, bus.x_in, bus.y_in});
        else if (expDrop < 131071) expDrop++;
      end
      expWr = 1'b0;
      if (inClear(cyc + 1)) begin
        expWr = 1'b1; expAddr = cyc - lastFs; expData = 0;
      end
      if (pending.size() > 0 && pending[0].due == cyc + 1) begin
        p = pending.pop_front();
        if (int'(p.x) < H && int'(p.y) < V) begin
          expWr = 1'b1; expAddr = int'(p.y) * H + int'(p.x); expData = 8'hFF;
          if (expPlot < 131071) expPlot++;
        end else if (expDrop < 131071) expDrop++;
      end
      expReady = inDraw(cyc + 1);
      expBusy  = inClear(cyc + 1);
      cyc++;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_wr_en", 32'(bus.wr_en_out), 32'(expWr));
      if (expWr) begin
        checkOutput("m_wr_addr", 32'(bus.wr_addr_out), 32'(expAddr));
        checkOutput("m_wr_data", 32'(bus.wr_data_out), 32'(expData));
      end
      checkOutput("m_ready", 32'(bus.ready_out), 32'(expReady));
      checkOutput("m_busy", 32'(bus.busy_out), 32'(expBusy));
      checkOutput("m_plotted", 32'(bus.plotted_cnt_out), 32'(expPlot));
      checkOutput("m_dropped", 32'(bus.dropped_cnt_out), 32'(expDrop));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with literal checkpoints, then random traffic.
  initial begin
    int cnt;
    bus.x_in = '0; bus.y_in = '0; bus.valid_in = 1'b0; bus.frame_start_in = 1'b0;
    #2 rst_n = 1'b0;
    checkEn = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("resetReady", 32'(bus.ready_out), 32'd0);
    checkOutput("resetWrEn", 32'(bus.wr_en_out), 32'd0);

    // Frame 1: start clearing, then reset mid-clear.
    applyStimulus(1'b1, 1'b0, 9'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("firstClearEn", 32'(bus.wr_en_out), 32'd1);
    checkOutput("firstClearAddr", 32'(bus.wr_addr_out), 32'd0);
    checkOutput("firstClearBusy", 32'(bus.busy_out), 32'd1);
    idleCycles(50);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstWrEn", 32'(bus.wr_en_out), 32'd0);
    checkOutput("asyncRstAddr", 32'(bus.wr_addr_out), 32'd0);
    checkOutput("asyncRstBusy", 32'(bus.busy_out), 32'd0);
    checkOutput("asyncRstReady", 32'(bus.ready_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("idleReady", 32'(bus.ready_out), 32'd0);
    checkOutput("idleBusy", 32'(bus.busy_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 9'd3, 8'd3);
    applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("idleDrop", 32'(bus.dropped_cnt_out), 32'd1);

    // Frame 2: full clear with exact write count and DRAW entry time.
    applyStimulus(1'b1, 1'b0, 9'd0, 8'd0);
    cnt = 0;
    for (int k = 1; k <= PIX; k++) begin
      applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
      @(negedge clk);
      if (bus.wr_en_out === 1'b1 && bus.wr_addr_out == 17'(k - 1) && bus.wr_data_out == 8'h00) cnt++;
    end
    checkOutput("clearWrites", 32'(cnt), 32'd3840);
    checkOutput("lastClearAddr", 32'(bus.wr_addr_out), 32'd3839);
    checkOutput("readyDuringLastClear", 32'(bus.ready_out), 32'd0);
    applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("readyAtDraw", 32'(bus.ready_out), 32'd1);
    checkOutput("busyAtDraw", 32'(bus.busy_out), 32'd0);

    // Single point, corner point, rejected points, back-to-back stream.
    applyStimulus(1'b0, 1'b1, 9'd10, 8'd5);
    idleCycles(2);
    @(negedge clk);
    checkOutput("pointEn", 32'(bus.wr_en_out), 32'd1);
    checkOutput("pointAddr", 32'(bus.wr_addr_out), 32'd1610);
    checkOutput("pointData", 32'(bus.wr_data_out), 32'hFF);
    checkOutput("pointPlotted", 32'(bus.plotted_cnt_out), 32'd1);
    applyStimulus(1'b0, 1'b1, 9'd319, 8'd11);
    idleCycles(2);
    @(negedge clk);
    checkOutput("cornerAddr", 32'(bus.wr_addr_out), 32'd3839);
    applyStimulus(1'b0, 1'b1, 9'd320, 8'd0);
    applyStimulus(1'b0, 1'b1, 9'd0, 8'd12);
    applyStimulus(1'b0, 1'b1, 9'd511, 8'd100);
    idleCycles(2);
    @(negedge clk);
    checkOutput("rangeDropped", 32'(bus.dropped_cnt_out), 32'd3);
    checkOutput("rangePlotted", 32'(bus.plotted_cnt_out), 32'd2);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, 9'((i * 3) % H), 8'(i % V));
    idleCycles(2);
    @(negedge clk);
    checkOutput("burstPlotted", 32'(bus.plotted_cnt_out), 32'd102);
    randomCycles(1500);

    // Frame 3: restart mid-clear at address 1000, drop during clear.
    applyStimulus(1'b1, 1'b0, 9'd0, 8'd0);
    idleCycles(1000);
    applyStimulus(1'b1, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("restartFromAddr", 32'(bus.wr_addr_out), 32'd1000);
    applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("restartAddr0", 32'(bus.wr_addr_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 9'd5, 8'd5);
    applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("clearDrop", 32'(bus.dropped_cnt_out), 32'd1);
    waitReady(PIX + 20);
    randomCycles(500);

    // Abort with two points in flight.
    applyStimulus(1'b0, 1'b1, 9'd1, 8'd1);
    applyStimulus(1'b1, 1'b1, 9'd2, 8'd2);
    applyStimulus(1'b0, 1'b0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("abortAddr", 32'(bus.wr_addr_out), 32'd0);
    checkOutput("abortData", 32'(bus.wr_data_out), 32'd0);
    checkOutput("abortPlotted", 32'(bus.plotted_cnt_out), 32'd0);
    checkOutput("abortDropped", 32'(bus.dropped_cnt_out), 32'd0);
    waitReady(PIX + 20);
    randomCycles(1000);
    idleCycles(4);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
